// File: rtl/ram_read_sequencer_pkg.sv
// Shared definitions for the operand-RAM read sequencer: FSM state
// encodings and the default RAM read latency, so that the RAM wrapper and
// the sequencer agree on one value.
package ram_read_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE0 = 2'd3
    } seq_state_t;

    // Cycles from address issue to valid RAM data; legal range 1..4.
    localparam int DEFAULT_READ_LATENCY = 1;

endpackage

// File: rtl/ram_read_sequencer_if.sv
// Bundle of the request, RAM and capture-side signals of the read sequencer.
//
// Handshake: `start` is a one-cycle request that is accepted only while
// `busy` is low (and `abort` is low); there is no acknowledge, the rise of
// `busy` in the next cycle is the acceptance. On the capture side there is
// no ready/back-pressure: `data_valid` qualifies `data_out` for exactly one
// cycle per word and `counter_done` marks the final word (or the completion
// of a zero-length request), so the consumer must capture every valid word.
interface ram_read_sequencer_if #(
    parameter int n  = 6,
    parameter int AW = 4
);
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   num_words;
    logic          abort;
    logic          ram_en;
    logic [AW-1:0] ram_addr;
    logic [n-1:0]  ram_out;
    logic [n-1:0]  data_out;
    logic          data_valid;
    logic          counter_done;
    logic          busy;

    // Sequencer side.
    modport master (
        input  start, base_addr, num_words, abort, ram_out,
        output ram_en, ram_addr, data_out, data_valid, counter_done, busy
    );

    // Requester / RAM / capture side.
    modport slave (
        output start, base_addr, num_words, abort, ram_out,
        input  ram_en, ram_addr, data_out, data_valid, counter_done, busy
    );
endinterface

// File: rtl/valid_delay_line.sv
// Fixed-depth shift register of valid/last flags that tracks which RAM
// reads are in flight. A token entering here emerges DEPTH cycles later,
// aligned with the RAM data it belongs to. `flush` discards all tokens.
module valid_delay_line #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic flush,
    input  logic in_valid,
    input  logic in_last,
    output logic out_valid,
    output logic out_last
);

    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] last_q;

    // Shift tokens one stage per cycle; flush empties every stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            last_q  <= '0;
        end else if (flush) begin
            valid_q <= '0;
            last_q  <= '0;
        end else begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                valid_q[i] <= valid_q[i-1];
                last_q[i]  <= last_q[i-1];
            end
            valid_q[0] <= in_valid;
            last_q[0]  <= in_valid & in_last;
        end
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_last  = last_q[DEPTH-1];

endmodule

// File: rtl/ram_read_sequencer.sv
// Reads a block of consecutive words from the synchronous operand RAM and
// presents them one per cycle on data_out/data_valid, pulsing counter_done
// with the final word. Owns the RAM address counter and read enable and
// hides the RAM read latency behind a matching valid-token delay line.
module ram_read_sequencer
    import ram_read_sequencer_pkg::*;
#(
    parameter int n            = 6,
    parameter int AW           = 4,
    parameter int READ_LATENCY = DEFAULT_READ_LATENCY
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ram_read_sequencer_if.master bus,
    output seq_state_t           state_dbg
);

    seq_state_t    state_q;
    seq_state_t    state_d;
    logic [AW-1:0] addr_q;
    logic [AW:0]   remaining_q;
    logic          accept;
    logic          issue;
    logic          last_issue;
    logic          pipe_valid;
    logic          pipe_last;
    logic          dv_q;
    logic          done_q;
    logic [n-1:0]  data_q;

    // A request is taken only from IDLE, and abort always wins over start.
    assign accept     = (state_q == ST_IDLE) && bus.start && !bus.abort;
    assign issue      = (state_q == ST_ISSUE);
    assign last_issue = issue && (remaining_q == (AW+1)'(1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort returns to IDLE from any state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = (bus.num_words == '0) ? ST_DONE0 : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (last_issue) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // The final word is on the outputs this cycle.
                if (done_q) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DONE0: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (bus.abort) begin
            state_d = ST_IDLE;
        end
    end

    // Address and word counters: load on accept, step once per issued read.
    // Address arithmetic wraps modulo 2^AW by construction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q      <= '0;
            remaining_q <= '0;
        end else if (bus.abort) begin
            remaining_q <= '0;
        end else if (accept) begin
            addr_q      <= bus.base_addr;
            remaining_q <= bus.num_words;
        end else if (issue) begin
            addr_q      <= addr_q + AW'(1);
            remaining_q <= remaining_q - (AW+1)'(1);
        end
    end

    valid_delay_line #(
        .DEPTH (READ_LATENCY)
    ) u_valid_delay_line (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (bus.abort),
        .in_valid  (issue),
        .in_last   (last_issue),
        .out_valid (pipe_valid),
        .out_last  (pipe_last)
    );

    // Capture register: when a token emerges its RAM word is on ram_out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dv_q   <= 1'b0;
            done_q <= 1'b0;
            data_q <= '0;
        end else begin
            dv_q   <= pipe_valid & ~bus.abort;
            done_q <= pipe_valid & pipe_last & ~bus.abort;
            if (pipe_valid) begin
                data_q <= bus.ram_out;
            end
        end
    end

    assign bus.ram_en       = issue;
    assign bus.ram_addr     = issue ? addr_q : '0;
    assign bus.data_out     = data_q;
    assign bus.data_valid   = dv_q;
    assign bus.counter_done = done_q | (state_q == ST_DONE0);
    assign bus.busy         = (state_q != ST_IDLE);
    assign state_dbg        = state_q;

endmodule
